vga_stream_monitor: RTL and testbench
=====================================

// Module: vga_stream_monitor
// PURPOSE
//  Receive-side decoder for the 29-bit packed VGA bus produced by the vga display block.
//  Recovers pixel clock, syncs, blanking and RGB; regenerates x/y; checks frame geometry;
//  computes a per-frame CRC-16 signature of the active pixels.
//  Sits beside the display path, or in loopback benches, as a self-check and capture point.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line (pix_x range 0..H_ACTIVE-1)
//  V_ACTIVE  480  active lines per frame (pix_y range 0..V_ACTIVE-1)
// PORTS
//  clk              in   1   system clock; the only clock
//  rst              in   1   reset, synchronous, active-low
//  vga_output_data  in   29  packed bus: [28] vga_clk, [27] blank_n, [26] sync_n,
//                            [25] hsync_n, [24] vsync_n, [23:16] r, [15:8] g, [7:0] b
//  pix_valid        out  1   one-clk strobe: active pixel presented on pix_*
//  pix_x, pix_y     out  10  coordinates of the presented pixel
//  pix_r/g/b        out  8   colour of the presented pixel
//  frame_start      out  1   one-clk pulse with the first pixel (0,0) of a frame while locked
//  frame_done       out  1   one-clk pulse when a complete, error-free frame is checked
//  frame_sig        out  16  CRC-16 of the last completed frame; held until the next frame_done
//  locked           out  1   geometry tracking is established
//  h_len_err        out  1   one-clk pulse: active line length != H_ACTIVE
//  v_len_err        out  1   one-clk pulse: active line count != V_ACTIVE at vsync
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): all outputs 0, state HUNT, counters 0, CRC = 16'hFFFF.
//  Sampling: the bus is registered every clk (in_q). A pixel tick occurs when in_q[28]==1
//   and the previous in_q[28]==0. All other logic advances only on ticks. pix_* update on
//   the clk after the tick: 2 clk from a vga_clk rise on the input bus to pix_valid.
//  No vga_clk edges: the block holds state indefinitely and raises no errors.
//  FSM (one tick per transition):
//   HUNT   -> SYNC   on vsync_n falling edge (1 -> 0 between consecutive ticks)
//   SYNC   -> LOCKED on first tick with blank_n==1 after vsync_n has returned to 1;
//             that pixel is (0,0): frame_start pulses, CRC seeded to 16'hFFFF
//   LOCKED -> HUNT   on h_len_err or v_len_err; locked drops the same clk as the error pulse
//  locked==1 only in LOCKED. pix_valid fires only in LOCKED on ticks with blank_n==1.
//  x counter: increments per active tick; on blank_n 1->0 compare x with H_ACTIVE
//   (mismatch -> h_len_err), then clear x and increment y.
//  y counter: on vsync_n falling edge in LOCKED compare y with V_ACTIVE; mismatch ->
//   v_len_err; match -> frame_done pulse, frame_sig <= CRC; then clear y, CRC <= 16'hFFFF;
//   the next active tick is (0,0) and pulses frame_start.
//  Counters saturate at 1023; no wrap. Comparison uses the saturated value.
//  CRC: CCITT polynomial 16'h1021, per active pixel over {r,g,b} (24 bits, MSB first),
//   no reflection, no final XOR; the per-pixel update completes within one clk.
//  Simultaneous events on one tick: the blank_n falling-edge line check is evaluated before
//   the vsync_n check. If both fail, both error pulses fire on the same clk.
//  sync_n is decoded but ignored (reserved).
//  Reset mid-operation: outputs clear on the next clk; relock requires a fresh vsync.
// STRUCTURE
//  Package vga_pkg: bus bit-position constants (VGA_CLK_BIT=28 ... B_LSB=0), default
//   timing constants, FSM state enum {HUNT, SYNC, LOCKED}, function crc16_px(crc, rgb24).
//  Sub-module vga_bus_sampler: input register, vga_clk rise -> tick, and edge flags for
//   blank_n and vsync_n, updated on ticks. The top level holds the FSM, counters and CRC.
// TESTING (bench drives the vga display block, H_ACTIVE=8, V_ACTIVE=4 for speed)
//  1 rst=0 for 3 clk mid-stream -> all outputs 0, locked=0; no pix_valid until after a vsync
//  2 constant r=12 g=34 b=56, 3 frames -> locked after 1st vsync; 32 pix_valid per frame,
//    last pixel x=7,y=3; frame_done once per frame; frame_sig == model CRC; no errors
//  3 gradient r=x[7:0], g=y[7:0] -> each pix_valid: pix_r==pix_x, pix_g==pix_y;
//    frame_start coincident with (0,0)
//  4 one line forced to 7 active pixels -> h_len_err one clk at that line end, locked=0,
//    no frame_done for that frame; relock and correct signature on the following frame
//  5 vsync after only 3 active lines -> v_len_err pulse, locked drops, relock next frame
//  6 vga_clk held 0 for 1000 clk mid-line -> pix_valid stays 0, no error pulses; resumes cleanly

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the packed VGA bus monitor: bus bit map, widths, FSM states, CRC helper.
package vga_pkg;

    localparam int unsigned BUS_W        = 29;
    localparam int unsigned VGA_CLK_BIT  = 28;
    localparam int unsigned BLANK_N_BIT  = 27;
    localparam int unsigned SYNC_N_BIT   = 26;
    localparam int unsigned HSYNC_N_BIT  = 25;
    localparam int unsigned VSYNC_N_BIT  = 24;
    localparam int unsigned R_MSB        = 23;
    localparam int unsigned R_LSB        = 16;
    localparam int unsigned G_MSB        = 15;
    localparam int unsigned G_LSB        = 8;
    localparam int unsigned B_MSB        = 7;
    localparam int unsigned B_LSB        = 0;

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned COL_W        = 8;
    localparam int unsigned CRC_W        = 16;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    // CRC-16/CCITT over one 24-bit pixel, MSB first, no reflection
    function automatic logic [CRC_W-1:0] crc16_px(input logic [CRC_W-1:0] crc,
                                                  input logic [3*COL_W-1:0] rgb24);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = 3*COL_W-1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ rgb24[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            else                       c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_bus_sampler.sv
// Registers the VGA bus, turns vga_clk rises into one-clk ticks, and tracks blank_n/vsync_n edges per tick.
module vga_bus_sampler
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] i_bus,
    output logic             o_tick_c,
    output logic             o_blank_n_c,
    output logic             o_vsync_n_c,
    output logic             o_blank_fall_c,
    output logic             o_vsync_fall_c,
    output rgb_t             o_rgb_c
);

    logic [BUS_W-1:0] r_in_q;
    logic             r_clk_prev;
    logic             r_blank_prev;
    logic             r_vsync_prev;
    logic             w_unused_ok;

    // Capture the bus and the previous vga_clk level every clk
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_q     <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_in_q     <= i_bus;
            r_clk_prev <= r_in_q[VGA_CLK_BIT];
        end
    end

    assign o_tick_c    = r_in_q[VGA_CLK_BIT] & ~r_clk_prev;
    assign o_blank_n_c = r_in_q[BLANK_N_BIT];
    assign o_vsync_n_c = r_in_q[VSYNC_N_BIT];
    assign o_rgb_c     = r_in_q[R_MSB:B_LSB];

    // History cleared to 0 so no edge can be reported before two ticks have been seen
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blank_prev <= 1'b0;
            r_vsync_prev <= 1'b0;
        end else if (o_tick_c) begin
            r_blank_prev <= o_blank_n_c;
            r_vsync_prev <= o_vsync_n_c;
        end
    end

    assign o_blank_fall_c = o_tick_c & r_blank_prev & ~o_blank_n_c;
    assign o_vsync_fall_c = o_tick_c & r_vsync_prev & ~o_vsync_n_c;

    // sync_n and hsync_n are carried on the bus but play no part in tracking
    assign w_unused_ok = ^{r_in_q[SYNC_N_BIT], r_in_q[HSYNC_N_BIT]};

endmodule

// File: rtl/vga_stream_monitor.sv
// Receive-side VGA bus decoder: pixel recovery, x/y regeneration, geometry checks, per-frame CRC.
module vga_stream_monitor
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] vga_output_data,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [COL_W-1:0] pix_r,
    output logic [COL_W-1:0] pix_g,
    output logic [COL_W-1:0] pix_b,
    output logic             frame_start,
    output logic             frame_done,
    output logic [CRC_W-1:0] frame_sig,
    output logic             locked,
    output logic             h_len_err,
    output logic             v_len_err
);

    localparam logic [CNT_W-1:0] H_CMP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_CMP = CNT_W'(V_ACTIVE);

    logic             w_tick;
    logic             w_blank_n;
    logic             w_vsync_n;
    logic             w_blank_fall;
    logic             w_vsync_fall;
    rgb_t             w_rgb;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CRC_W-1:0] r_crc;

    logic             w_enter_lock;
    logic             w_pix;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_h_err;
    logic             w_v_err;
    logic             w_frame_ok;
    logic [CNT_W-1:0] w_y_line;
    logic [CNT_W-1:0] w_px_x;
    logic [CNT_W-1:0] w_px_y;
    logic [CRC_W-1:0] w_crc_base;

    vga_bus_sampler u_sampler (
        .clk            (clk),
        .rst            (rst),
        .i_bus          (vga_output_data),
        .o_tick_c       (w_tick),
        .o_blank_n_c    (w_blank_n),
        .o_vsync_n_c    (w_vsync_n),
        .o_blank_fall_c (w_blank_fall),
        .o_vsync_fall_c (w_vsync_fall),
        .o_rgb_c        (w_rgb)
    );

    // Tracking state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= HUNT;
        else      r_state <= w_state_nxt;
    end

    // Next state and per-tick events; the line check runs before the frame check
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_lock = 1'b0;
        w_pix        = 1'b0;
        w_line_end   = 1'b0;
        w_frame_end  = 1'b0;
        w_h_err      = 1'b0;
        w_v_err      = 1'b0;
        w_y_line     = r_y;
        case (r_state)
            HUNT: begin
                if (w_vsync_fall) w_state_nxt = SYNC;
            end
            SYNC: begin
                if (w_tick && w_blank_n && w_vsync_n) begin
                    w_state_nxt  = LOCKED;
                    w_enter_lock = 1'b1;
                    w_pix        = 1'b1;
                end
            end
            LOCKED: begin
                if (w_tick) begin
                    w_pix = w_blank_n;
                    if (w_blank_fall) begin
                        w_line_end = 1'b1;
                        w_h_err    = (r_x != H_CMP);
                        w_y_line   = sat_inc(r_y);
                    end
                    if (w_vsync_fall) begin
                        w_frame_end = 1'b1;
                        w_v_err     = (w_y_line != V_CMP);
                    end
                    if (w_h_err || w_v_err) w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    assign w_frame_ok = w_frame_end & ~w_h_err & ~w_v_err;
    assign w_px_x     = w_enter_lock ? '0 : r_x;
    assign w_px_y     = w_enter_lock ? '0 : r_y;
    assign w_crc_base = w_enter_lock ? CRC_SEED : r_crc;

    // Position counters and running CRC of the current frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_crc <= CRC_SEED;
        end else begin
            if (w_pix) begin
                r_x   <= sat_inc(w_px_x);
                r_crc <= crc16_px(w_crc_base, w_rgb);
            end
            if (w_line_end) r_x <= '0;
            if (w_enter_lock || w_frame_end) r_y <= '0;
            else if (w_line_end)             r_y <= w_y_line;
            if (w_frame_end) r_crc <= CRC_SEED;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_sig   <= '0;
            locked      <= 1'b0;
            h_len_err   <= 1'b0;
            v_len_err   <= 1'b0;
        end else begin
            pix_valid   <= w_pix;
            frame_start <= w_pix && (w_px_x == '0) && (w_px_y == '0);
            frame_done  <= w_frame_ok;
            locked      <= (w_state_nxt == LOCKED);
            h_len_err   <= w_h_err;
            v_len_err   <= w_v_err;
            if (w_pix) begin
                pix_x <= w_px_x;
                pix_y <= w_px_y;
                pix_r <= w_rgb.r;
                pix_g <= w_rgb.g;
                pix_b <= w_rgb.b;
            end
            if (w_frame_ok) frame_sig <= r_crc;
        end
    end

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Bench for vga_stream_monitor: drives a small-geometry VGA raster and checks against a frame-level model.
module tb_vga_stream_monitor;

    localparam int HA      = 8;
    localparam int VA      = 4;
    localparam int H_TOTAL = 14;
    localparam int V_TOTAL = 7;
    localparam int VS_LINE = 5;
    localparam int FRAME_PX = HA * VA;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] bus;

    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        frame_start, frame_done;
    logic [15:0] frame_sig;
    logic        locked, h_len_err, v_len_err;

    vga_stream_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clk             (clk),
        .rst             (rst),
        .vga_output_data (bus),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_r           (pix_r),
        .pix_g           (pix_g),
        .pix_b           (pix_b),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .frame_sig       (frame_sig),
        .locked          (locked),
        .h_len_err       (h_len_err),
        .v_len_err       (v_len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    px_t         gen_q[$];
    px_t         obs_q[$];
    logic [15:0] sig_q[$];
    px_t         log_px;
    int n_start, n_start_bad, n_herr, n_verr, n_err_locked;
    int stall_obs_before, stall_obs_after, stall_err_before, stall_err_after;
    int total = 0;
    int bad   = 0;

    // Record every DUT observation away from the active edge
    always @(negedge clk) begin
        if (pix_valid) begin
            log_px.x = pix_x; log_px.y = pix_y;
            log_px.r = pix_r; log_px.g = pix_g; log_px.b = pix_b;
            obs_q.push_back(log_px);
        end
        if (frame_done) sig_q.push_back(frame_sig);
        if (frame_start) begin
            n_start++;
            if (!(pix_valid && pix_x == 10'd0 && pix_y == 10'd0)) n_start_bad++;
        end
        if (h_len_err) n_herr++;
        if (v_len_err) n_verr++;
        if ((h_len_err || v_len_err) && locked) n_err_locked++;
    end

    // Reference signature: CRC-CCITT computed byte-wise over r,g,b of one generated frame
    function automatic logic [15:0] exp_sig(input int base);
        logic [15:0] c;
        logic [7:0]  byt [3];
        px_t p;
        c = 16'hFFFF;
        for (int i = 0; i < FRAME_PX; i++) begin
            if (base + i < gen_q.size()) begin
                p = gen_q[base + i];
                byt[0] = p.r; byt[1] = p.g; byt[2] = p.b;
                for (int k = 0; k < 3; k++) begin
                    c = c ^ {byt[k], 8'h00};
                    for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
                end
            end
        end
        return c;
    endfunction

    task automatic clear_log();
        gen_q.delete(); obs_q.delete(); sig_q.delete();
        n_start = 0; n_start_bad = 0; n_herr = 0; n_verr = 0; n_err_locked = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // One pixel: low phase with data, optional stall, then vga_clk high
    task automatic drive_px(input logic bl, input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int stall);
        bus = {1'b0, bl, 1'b1, hs, vs, r, g, b};
        repeat (2) @(negedge clk);
        if (stall > 0) begin
            stall_obs_before = obs_q.size();
            stall_err_before = n_herr + n_verr;
            repeat (stall) @(negedge clk);
            stall_obs_after = obs_q.size();
            stall_err_after = n_herr + n_verr;
        end
        bus[28] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // mode 0 constant, 1 gradient, 2 random colours
    task automatic gen_frame(input int mode, input int short_line, input int act_lines,
                             input bit keep, input int stall_line);
        logic bl, hs, vs;
        logic [7:0] r, g, b;
        int alen;
        px_t p;
        for (int ln = 0; ln < V_TOTAL; ln++) begin
            for (int px = 0; px < H_TOTAL; px++) begin
                alen = (ln == short_line) ? HA - 1 : HA;
                bl = (ln < act_lines) && (px < alen);
                hs = !(px >= 10 && px < 12);
                vs = (ln != VS_LINE);
                case (mode)
                    0:       begin r = 8'd12;     g = 8'd34;     b = 8'd56;         end
                    1:       begin r = 8'(px);    g = 8'(ln);    b = 8'($urandom);  end
                    default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
                endcase
                if (bl && keep) begin
                    p.x = 10'(px); p.y = 10'(ln); p.r = r; p.g = g; p.b = b;
                    gen_q.push_back(p);
                end
                drive_px(bl, hs, vs, r, g, b, (ln == stall_line && px == 3) ? 1000 : 0);
            end
        end
    endtask

    task automatic test_reset();
        int mark;
        rst = 1'b0; bus = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, frame_done,
             frame_sig, locked, h_len_err, v_len_err} !== '0) begin
            bad++; $display("FAIL reset_outputs got_nonzero locked=%b sig=%h", locked, frame_sig);
        end
        rst = 1'b1;
        clear_log();
        gen_frame(2, -1, VA, 0, -1);
        gen_frame(2, -1, VA, 0, -1);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL reset_prelock got=%b exp=1", locked); end
        mark = 0;
        fork
            gen_frame(2, -1, VA, 0, -1);
            begin
                repeat (150) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                total++;
                if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, frame_done,
                     frame_sig, locked, h_len_err, v_len_err} !== '0) begin
                    bad++; $display("FAIL reset_midstream got_nonzero locked=%b sig=%h", locked, frame_sig);
                end
                rst = 1'b1;
                mark = obs_q.size();
            end
        join
        total++;
        if (obs_q.size() != mark) begin
            bad++; $display("FAIL reset_no_pix got=%0d exp=%0d", obs_q.size() - mark, 0);
        end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL reset_unlocked got=%b exp=0", locked); end
        clear_log();
        gen_frame(2, -1, VA, 1, -1);
        total++;
        if (sig_q.size() != 1 || sig_q[0] !== exp_sig(0)) begin
            bad++; $display("FAIL reset_relock_sig n=%0d got=%h exp=%h", sig_q.size(),
                            (sig_q.size() > 0) ? sig_q[0] : 16'h0, exp_sig(0));
        end
    endtask

    task automatic test_constant();
        do_reset(); clear_log();
        gen_frame(0, -1, VA, 0, -1);
        for (int f = 0; f < 3; f++) gen_frame(0, -1, VA, 1, -1);
        total++;
        if (obs_q.size() != 3 * FRAME_PX) begin
            bad++; $display("FAIL const_count got=%0d exp=%0d", obs_q.size(), 3 * FRAME_PX);
        end
        for (int i = 0; i < obs_q.size() && i < gen_q.size(); i++) begin
            total++;
            if (obs_q[i] !== gen_q[i]) begin
                bad++; $display("FAIL const_px[%0d] got=%h exp=%h", i, obs_q[i], gen_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[obs_q.size()-1].x !== 10'd7 || obs_q[obs_q.size()-1].y !== 10'd3) begin
                bad++; $display("FAIL const_last got=(%0d,%0d) exp=(7,3)",
                                obs_q[obs_q.size()-1].x, obs_q[obs_q.size()-1].y);
            end
        end
        total++;
        if (sig_q.size() != 3) begin bad++; $display("FAIL const_done_count got=%0d exp=3", sig_q.size()); end
        for (int f = 0; f < sig_q.size() && f < 3; f++) begin
            total++;
            if (sig_q[f] !== exp_sig(f * FRAME_PX)) begin
                bad++; $display("FAIL const_sig[%0d] got=%h exp=%h", f, sig_q[f], exp_sig(f * FRAME_PX));
            end
        end
        total++;
        if (n_herr + n_verr != 0) begin bad++; $display("FAIL const_errs got=%0d exp=0", n_herr + n_verr); end
        total++;
        if (n_start != 3 || n_start_bad != 0) begin
            bad++; $display("FAIL const_start got=%0d/%0d exp=3/0", n_start, n_start_bad);
        end
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL const_locked got=%b exp=1", locked); end
    endtask

    task automatic test_gradient();
        do_reset(); clear_log();
        gen_frame(1, -1, VA, 0, -1);
        gen_frame(1, -1, VA, 1, -1);
        gen_frame(1, -1, VA, 1, -1);
        total++;
        if (obs_q.size() != 2 * FRAME_PX) begin
            bad++; $display("FAIL grad_count got=%0d exp=%0d", obs_q.size(), 2 * FRAME_PX);
        end
        for (int i = 0; i < obs_q.size() && i < gen_q.size(); i++) begin
            total++;
            if (obs_q[i].r !== obs_q[i].x[7:0] || obs_q[i].g !== obs_q[i].y[7:0] || obs_q[i] !== gen_q[i]) begin
                bad++; $display("FAIL grad_px[%0d] got=%h exp=%h", i, obs_q[i], gen_q[i]);
            end
        end
        total++;
        if (n_start != 2 || n_start_bad != 0) begin
            bad++; $display("FAIL grad_start got=%0d/%0d exp=2/0", n_start, n_start_bad);
        end
        for (int f = 0; f < 2; f++) begin
            total++;
            if (f >= sig_q.size() || sig_q[f] !== exp_sig(f * FRAME_PX)) begin
                bad++; $display("FAIL grad_sig[%0d] n=%0d exp=%h", f, sig_q.size(), exp_sig(f * FRAME_PX));
            end
        end
    endtask

    task automatic test_h_len();
        do_reset(); clear_log();
        gen_frame(2, -1, VA, 0, -1);
        gen_frame(2, 2, VA, 0, -1);
        total++;
        if (n_herr != 1 || n_verr != 0) begin
            bad++; $display("FAIL hlen_pulses got=%0d/%0d exp=1/0", n_herr, n_verr);
        end
        total++;
        if (n_err_locked != 0) begin bad++; $display("FAIL hlen_lock_drop got=%0d exp=0", n_err_locked); end
        total++;
        if (sig_q.size() != 0) begin bad++; $display("FAIL hlen_no_done got=%0d exp=0", sig_q.size()); end
        total++;
        if (obs_q.size() != 2 * HA + HA - 1) begin
            bad++; $display("FAIL hlen_pix_before got=%0d exp=%0d", obs_q.size(), 2 * HA + HA - 1);
        end
        clear_log();
        gen_frame(2, -1, VA, 1, -1);
        total++;
        if (obs_q.size() != FRAME_PX) begin bad++; $display("FAIL hlen_relock_count got=%0d exp=%0d", obs_q.size(), FRAME_PX); end
        for (int i = 0; i < obs_q.size() && i < gen_q.size(); i++) begin
            total++;
            if (obs_q[i] !== gen_q[i]) begin bad++; $display("FAIL hlen_px[%0d] got=%h exp=%h", i, obs_q[i], gen_q[i]); end
        end
        total++;
        if (sig_q.size() != 1 || sig_q[0] !== exp_sig(0)) begin
            bad++; $display("FAIL hlen_sig n=%0d exp=%h", sig_q.size(), exp_sig(0));
        end
    endtask

    task automatic test_v_len();
        do_reset(); clear_log();
        gen_frame(2, -1, VA, 0, -1);
        gen_frame(2, -1, VA - 1, 0, -1);
        total++;
        if (n_verr != 1 || n_herr != 0) begin
            bad++; $display("FAIL vlen_pulses got=%0d/%0d exp=0/1", n_herr, n_verr);
        end
        total++;
        if (n_err_locked != 0 || locked !== 1'b0) begin
            bad++; $display("FAIL vlen_lock_drop got=%0d/%b exp=0/0", n_err_locked, locked);
        end
        total++;
        if (sig_q.size() != 0 || obs_q.size() != (VA - 1) * HA) begin
            bad++; $display("FAIL vlen_frame got=%0d/%0d exp=0/%0d", sig_q.size(), obs_q.size(), (VA - 1) * HA);
        end
        clear_log();
        gen_frame(2, -1, VA, 0, -1);
        gen_frame(2, -1, VA, 1, -1);
        total++;
        if (obs_q.size() != FRAME_PX) begin bad++; $display("FAIL vlen_relock_count got=%0d exp=%0d", obs_q.size(), FRAME_PX); end
        for (int i = 0; i < obs_q.size() && i < gen_q.size(); i++) begin
            total++;
            if (obs_q[i] !== gen_q[i]) begin bad++; $display("FAIL vlen_px[%0d] got=%h exp=%h", i, obs_q[i], gen_q[i]); end
        end
        total++;
        if (sig_q.size() != 1 || sig_q[0] !== exp_sig(0) || n_verr + n_herr != 0) begin
            bad++; $display("FAIL vlen_sig n=%0d errs=%0d exp=%h", sig_q.size(), n_verr + n_herr, exp_sig(0));
        end
    endtask

    task automatic test_stall();
        do_reset(); clear_log();
        gen_frame(2, -1, VA, 0, -1);
        gen_frame(2, -1, VA, 1, 1);
        total++;
        if (stall_obs_after != stall_obs_before || stall_err_after != stall_err_before) begin
            bad++; $display("FAIL stall_quiet got=%0d/%0d exp=0/0",
                            stall_obs_after - stall_obs_before, stall_err_after - stall_err_before);
        end
        total++;
        if (obs_q.size() != FRAME_PX) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), FRAME_PX); end
        for (int i = 0; i < obs_q.size() && i < gen_q.size(); i++) begin
            total++;
            if (obs_q[i] !== gen_q[i]) begin bad++; $display("FAIL stall_px[%0d] got=%h exp=%h", i, obs_q[i], gen_q[i]); end
        end
        total++;
        if (sig_q.size() != 1 || sig_q[0] !== exp_sig(0) || locked !== 1'b1) begin
            bad++; $display("FAIL stall_sig n=%0d locked=%b exp=%h", sig_q.size(), locked, exp_sig(0));
        end
    endtask

    initial begin
        rst = 1'b0;
        bus = '0;
        @(negedge clk);
        test_reset();
        test_constant();
        test_gradient();
        test_h_len();
        test_v_len();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
